// File: rtl/ctrl_pkg.sv
// Shared types for the RAM-driver sequencer: FSM states and header command encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INC   = 3'd2,
    HEAD  = 3'd3,
    WRITE = 3'd4,
    TAPS  = 3'd5,
    DONE  = 3'd6
  } seq_state_t;

  // Header command word is {init, head_inc, read}; one-hot by construction.
  localparam logic [2:0] CMD_SLEEP          = 3'b000;
  localparam logic [2:0] CMD_LOAD_LENGTH    = 3'b100;
  localparam logic [2:0] CMD_HEAD_INCREMENT = 3'b010;
  localparam logic [2:0] CMD_READ_HEAD      = 3'b001;

endpackage

// File: rtl/ctrl_ramdrv_tapptr.sv
// Tap pointer: walks the ring from the latched head towards older samples,
// wrapping 0 -> L, and counts taps so the last one can be flagged.
module ctrl_ramdrv_tapptr #(
  parameter int DATA_OFFSET_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic [DATA_OFFSET_WIDTH-1:0] i_load_ptr,
  input  logic                         i_step,
  input  logic [DATA_OFFSET_WIDTH-1:0] i_len,
  output logic [DATA_OFFSET_WIDTH-1:0] o_ptr,
  output logic                         o_first,
  output logic                         o_last
);

  logic [DATA_OFFSET_WIDTH-1:0] r_ptr;
  logic [DATA_OFFSET_WIDTH-1:0] r_k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_k   <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_ptr;
      r_k   <= '0;
    end else if (i_step) begin
      // Never stepped on the last tap, so k cannot overflow even when L is all ones.
      r_k   <= r_k + 1'b1;
      r_ptr <= (r_ptr == '0) ? i_len : r_ptr - 1'b1;
    end
  end

  assign o_ptr   = r_ptr;
  assign o_first = (r_k == '0);
  assign o_last  = (r_k == i_len);

endmodule

// File: rtl/ctrl_ramdrv_seq.sv
// Per-sample sequencer: advances a vector's ring head, writes the new sample
// there and streams len+1 tap read addresses, newest to oldest.
module ctrl_ramdrv_seq
  import ctrl_pkg::*;
#(
  parameter int DATA_OFFSET_WIDTH  = 10,
  parameter int VECTOR_INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH         = 14,
  parameter int DATA_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [VECTOR_INDEX_WIDTH-1:0] start_index,
  input  logic [DATA_OFFSET_WIDTH-1:0]  start_length,
  input  logic [ADDR_WIDTH-1:0]         start_base,
  input  logic [DATA_WIDTH-1:0]         start_sample,
  output logic                          hdr_init,
  output logic                          hdr_head_inc,
  output logic                          hdr_read,
  output logic [VECTOR_INDEX_WIDTH-1:0] hdr_index,
  output logic [DATA_OFFSET_WIDTH-1:0]  hdr_length,
  input  logic [DATA_OFFSET_WIDTH-1:0]  hdr_head_offset,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_we,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  output logic                          ram_re,
  input  logic                          tap_ready,
  output logic                          tap_first,
  output logic                          tap_last,
  output logic                          done
);

  seq_state_t r_state, w_next;

  logic [VECTOR_INDEX_WIDTH-1:0] r_idx;
  logic [DATA_OFFSET_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH-1:0]         r_base;
  logic [DATA_WIDTH-1:0]         r_sample;

  logic                         w_accept;
  logic                         w_step;
  logic                         w_first;
  logic                         w_last;
  logic [DATA_OFFSET_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0]        w_addr;
  logic [2:0]                   w_cmd;

  assign start_ready = (r_state == IDLE);
  assign w_accept    = start_ready & start_valid;
  assign w_step      = (r_state == TAPS) & tap_ready & ~w_last;
  // Offset is zero-extended; the sum wraps silently at the RAM size.
  assign w_addr      = r_base + ADDR_WIDTH'(w_ptr);
  assign {hdr_init, hdr_head_inc, hdr_read} = w_cmd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_len    <= '0;
      r_base   <= '0;
      r_sample <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx    <= start_index;
        r_len    <= start_length;
        r_base   <= start_base;
        r_sample <= start_sample;
      end
    end
  end

  ctrl_ramdrv_tapptr #(
    .DATA_OFFSET_WIDTH(DATA_OFFSET_WIDTH)
  ) u_tapptr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (r_state == HEAD),
    .i_load_ptr(hdr_head_offset),
    .i_step    (w_step),
    .i_len     (r_len),
    .o_ptr     (w_ptr),
    .o_first   (w_first),
    .o_last    (w_last)
  );

  always_comb begin
    w_next     = r_state;
    w_cmd      = CMD_SLEEP;
    hdr_index  = '0;
    hdr_length = '0;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    ram_re     = 1'b0;
    tap_first  = 1'b0;
    tap_last   = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: if (start_valid) w_next = LOAD;
      LOAD: begin
        w_cmd      = CMD_LOAD_LENGTH;
        hdr_index  = r_idx;
        hdr_length = r_len;
        w_next     = INC;
      end
      INC: begin
        w_cmd     = CMD_HEAD_INCREMENT;
        hdr_index = r_idx;
        w_next    = HEAD;
      end
      HEAD: begin
        w_cmd     = CMD_READ_HEAD;
        hdr_index = r_idx;
        w_next    = WRITE;
      end
      WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = w_addr;
        ram_wdata = r_sample;
        w_next    = TAPS;
      end
      TAPS: begin
        ram_re    = 1'b1;
        ram_addr  = w_addr;
        tap_first = w_first;
        tap_last  = w_last;
        if (tap_ready && w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
